lsu: RTL and testbench

Load/store unit: the initiator side of the data-memory port. It accepts one load or store request at a time from the CPU execute stage over a valid/ready handshake and drives the data-memory control signals (`en`, `write`, `size`, `addr`, `data_in`). For loads it captures the memory's 32-bit read word, then sign- or zero-extends it to XLEN. It returns a registered response with an optional fault flag and sits between the execute stage and the data memory.

---
 rtl/lsu_if.sv | 36 +++
 rtl/lsu.sv | 119 +++++++++++
 tb/tb_lsu.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Load/store unit bus: CPU request/response handshake plus data-memory port.
// slave = LSU view, master = CPU/memory environment view.
interface lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            resp_fault;
  logic            mem_en;
  logic            mem_write;
  logic [1:0]      mem_size;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_fault,
    output mem_en, mem_write, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_fault,
    input  mem_en, mem_write, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request at a time, IDLE -> ISSUE -> RESP, with load
// sign/zero extension. Ports: clk, rst_n, bus (lsu_if.slave).
// Optional macro LSU_BOUNDS_CHECK_EN: fault when addr + size > MEM_BYTES.
module lsu #(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 2048
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t          state, state_n;
  logic            wr_q;
  logic [2:0]      f3_q;
  logic [1:0]      size_q;
  logic [XLEN-1:0] addr_q, wdata_q, data_q;
  logic            fault_q;
  logic            f3_ok, in_bounds, legal, accept;
  logic [XLEN-1:0] ext;

  always_comb begin
    f3_ok = 1'b0;
    if (bus.req_write)
      f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010};
    else
      f3_ok = bus.req_funct3 inside {3'b000, 3'b001, 3'b010,
                                     3'b100, 3'b101};
  end

`ifdef LSU_BOUNDS_CHECK_EN
  // Extra carry bit makes an address wrap count as out of bounds.
  logic [XLEN:0] end_addr;
  assign end_addr = {1'b0, bus.req_addr}
                  + (XLEN+1)'(1 << bus.req_funct3[1:0]);
  assign in_bounds = end_addr <= (XLEN+1)'(MEM_BYTES);
`else
  assign in_bounds = 1'b1;
`endif

  assign legal  = f3_ok && in_bounds;
  assign accept = (state == IDLE) && bus.req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.req_valid) state_n = legal ? ISSUE : RESP;
      ISSUE:   state_n = RESP;
      RESP:    if (bus.resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ext = bus.mem_rdata;
    unique case (1'b1)
      f3_q == 3'b000:
        ext = {{(XLEN-8){bus.mem_rdata[7]}}, bus.mem_rdata[7:0]};
      f3_q == 3'b001:
        ext = {{(XLEN-16){bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      f3_q == 3'b100:
        ext = {{(XLEN-8){1'b0}}, bus.mem_rdata[7:0]};
      f3_q == 3'b101:
        ext = {{(XLEN-16){1'b0}}, bus.mem_rdata[15:0]};
      default:
        ext = bus.mem_rdata;
    endcase
  end

  // Memory-side fields only move on a legal accept so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      f3_q    <= '0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (accept) begin
        if (legal) begin
          wr_q    <= bus.req_write;
          f3_q    <= bus.req_funct3;
          size_q  <= bus.req_funct3[1:0];
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
        end else begin
          data_q  <= '0;
          fault_q <= 1'b1;
        end
      end
      if (state == ISSUE) begin
        fault_q <= 1'b0;
        data_q  <= wr_q ? '0 : ext;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_data  = data_q;
  assign bus.resp_fault = fault_q;
  assign bus.mem_en     = (state == ISSUE);
  assign bus.mem_write  = (state == ISSUE) && wr_q;
  assign bus.mem_size   = size_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a falling-edge byte memory model.
// Ports exercised: clk, rst_n and every lsu_if signal.
module tb_lsu;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   errs = 0;
  int   en_cnt = 0;
  logic [7:0] mem [2048];

  lsu_if #(.XLEN(32)) bus ();

  lsu #(.XLEN(32), .MEM_BYTES(2048)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_en) begin
      en_cnt++;
      if (bus.mem_write) begin
        for (int b = 0; b < (1 << bus.mem_size); b++)
          mem[11'(bus.mem_addr + b)] = bus.mem_wdata[8*b +: 8];
        bus.mem_rdata = 'z;
      end else begin
        bus.mem_rdata = {mem[11'(bus.mem_addr + 3)],
                         mem[11'(bus.mem_addr + 2)],
                         mem[11'(bus.mem_addr + 1)],
                         mem[11'(bus.mem_addr)]};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic flt,
                        output int waits);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    waits = 0;
    while (!bus.resp_valid && waits < 6) begin
      @(posedge clk); #1;
      waits++;
    end
    rd  = bus.resp_data;
    flt = bus.resp_fault;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd, hold;
  logic        flt;
  int          waits, c0;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    bus.mem_rdata  = '0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_size", 32'(bus.mem_size), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    c0 = en_cnt;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, flt, waits);
    chk("sw_fault", 32'(flt), 32'd0);
    chk("sw_data", rd, 32'h0);
    chk("sw_latency", 32'(waits), 32'd1);
    chk("sw_en_pulses", 32'(en_cnt - c0), 32'd1);
    chk("sw_req_ready", 32'(bus.req_ready), 32'd1);

    c0 = en_cnt;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, flt, waits);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_fault", 32'(flt), 32'd0);
    chk("lw_en_pulses", 32'(en_cnt - c0), 32'd1);

    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, flt, waits);
    chk("lb_data", rd, 32'hFFFFFFDE);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, rd, flt, waits);
    chk("lbu_data", rd, 32'h000000DE);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, rd, flt, waits);
    chk("lh_data", rd, 32'hFFFFDEAD);
    do_req(1'b0, 3'b101, 32'h10, 32'h0, rd, flt, waits);
    chk("lhu_data", rd, 32'h0000BEEF);

    do_req(1'b1, 3'b000, 32'h20, 32'h12345678, rd, flt, waits);
    chk("sb_mem_size", 32'(bus.mem_size), 32'd0);
    chk("sb_mem_wdata", bus.mem_wdata, 32'h12345678);
    chk("sb_mem_write_idle", 32'(bus.mem_write), 32'd0);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, flt, waits);
    chk("sb_readback", rd, 32'h00000078);

    c0 = en_cnt;
    do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, flt, waits);
    chk("bad_ld_fault", 32'(flt), 32'd1);
    chk("bad_ld_data", rd, 32'h0);
    chk("bad_ld_latency", 32'(waits), 32'd0);
    chk("bad_ld_en", 32'(en_cnt - c0), 32'd0);
    c0 = en_cnt;
    do_req(1'b1, 3'b100, 32'h10, 32'h1, rd, flt, waits);
    chk("bad_st_fault", 32'(flt), 32'd1);
    chk("bad_st_en", 32'(en_cnt - c0), 32'd0);

`ifdef LSU_BOUNDS_CHECK_EN
    c0 = en_cnt;
    do_req(1'b0, 3'b010, 32'h7FC, 32'h0, rd, flt, waits);
    chk("bnd_7fc_fault", 32'(flt), 32'd0);
    chk("bnd_7fc_en", 32'(en_cnt - c0), 32'd1);
    c0 = en_cnt;
    do_req(1'b0, 3'b010, 32'h7FD, 32'h0, rd, flt, waits);
    chk("bnd_7fd_fault", 32'(flt), 32'd1);
    chk("bnd_7fd_en", 32'(en_cnt - c0), 32'd0);
    do_req(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, rd, flt, waits);
    chk("bnd_wrap_fault", 32'(flt), 32'd1);
`else
    c0 = en_cnt;
    do_req(1'b0, 3'b010, 32'h7FD, 32'h0, rd, flt, waits);
    chk("nobnd_7fd_fault", 32'(flt), 32'd0);
    chk("nobnd_7fd_en", 32'(en_cnt - c0), 32'd1);
`endif

    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
    hold = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      chk("hold_data", bus.resp_data, hold);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", 32'(bus.req_ready), 32'd1);

    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h14;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("issue_mem_en", 32'(bus.mem_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("arst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("arst_mem_addr", bus.mem_addr, 32'h0);
    chk("arst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("arst_mem_size", 32'(bus.mem_size), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("arst_resp_data", bus.resp_data, 32'h0);
    chk("arst_resp_fault", 32'(bus.resp_fault), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
